// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared defaults and channel indices for input_conditioner.
package input_cond_pkg;

    localparam int unsigned IC_NUM_IN_DEF      = 5;
    localparam int unsigned IC_SYNC_STAGES_DEF = 2;
    // 10 ms at 100 MHz
    localparam int unsigned IC_DB_CYCLES_DEF   = 1_000_000;

    // Channel positions at integration: {INT2, INT1, DIP_SW[1:0], USER_BTN}
    localparam int unsigned CH_BTN  = 0;
    localparam int unsigned CH_DIP0 = 1;
    localparam int unsigned CH_DIP1 = 2;
    localparam int unsigned CH_INT1 = 3;
    localparam int unsigned CH_INT2 = 4;

    // Per-channel debounce state, derived from synchronised level vs dout
    typedef enum logic {
        CH_STABLE  = 1'b0,
        CH_PENDING = 1'b1
    } chan_state_e;

    // Counter width; a single-cycle debounce still needs one bit to exist
    function automatic int unsigned cnt_width(input int unsigned db_cycles);
        return (db_cycles > 1) ? $clog2(db_cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one input channel -- synchroniser chain, stability counter,
// registered debounced level and one-cycle rise/fall pulses.
module debounce_chan
    import input_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = IC_SYNC_STAGES_DEF,
    parameter int unsigned DB_CYCLES   = IC_DB_CYCLES_DEF,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   dout_next;
    logic                   rise_next;
    logic                   fall_next;
    chan_state_e            state;

    assign s = sync[SYNC_STAGES-1];

    // Synchroniser chain shifting the raw pin towards s
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // Derive channel state: pending whenever the synchronised level disagrees
    always_comb begin
        state = (s == dout) ? CH_STABLE : CH_PENDING;
    end

    // Next counter/level/pulse values from the derived state
    always_comb begin
        cnt_next  = '0;
        dout_next = dout;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if (state == CH_PENDING) begin
            if (cnt == CNT_LAST) begin
                dout_next = s;
                rise_next = s;
                fall_next = ~s;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    // Register counter, debounced level and edge pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            dout <= RESET_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            dout <= dout_next;
            rise <= rise_next;
            fall <= fall_next;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces NUM_IN slow asynchronous
// inputs. Define INPUT_COND_EDGE_IRQ_EN to add sticky edge capture
// (edge_cap, irq_clear, irq).
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned       NUM_IN      = IC_NUM_IN_DEF,
    parameter int unsigned       SYNC_STAGES = IC_SYNC_STAGES_DEF,
    parameter int unsigned       DB_CYCLES   = IC_DB_CYCLES_DEF,
    parameter logic [NUM_IN-1:0] RESET_VAL   = {NUM_IN{1'b1}}
`ifdef INPUT_COND_EDGE_IRQ_EN
   ,parameter logic [NUM_IN-1:0] CAP_MASK    = {NUM_IN{1'b1}}
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IN-1:0] din,
    output logic [NUM_IN-1:0] dout,
    output logic [NUM_IN-1:0] rise,
    output logic [NUM_IN-1:0] fall
`ifdef INPUT_COND_EDGE_IRQ_EN
   ,input  logic [NUM_IN-1:0] irq_clear,
    output logic [NUM_IN-1:0] edge_cap,
    output logic              irq
`endif
);

    for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .RESET_VAL   (RESET_VAL[i])
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .din   (din[i]),
            .dout  (dout[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

`ifdef INPUT_COND_EDGE_IRQ_EN
    logic [NUM_IN-1:0] cap_next;

    // Sticky capture: clear first, then OR in new edges so a coincident edge wins
    always_comb begin
        cap_next = (edge_cap & ~irq_clear) | ((rise | fall) & CAP_MASK);
    end

    // irq registered from the next capture value so it rises with edge_cap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            edge_cap <= cap_next;
            irq      <= |cap_next;
        end
    end
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of input_conditioner with DB_CYCLES=4
// and DB_CYCLES=1 instances; capture checks when INPUT_COND_EDGE_IRQ_EN is set.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] din4, dout4, rise4, fall4;
    logic [4:0] din1, dout1, rise1, fall1;
`ifdef INPUT_COND_EDGE_IRQ_EN
    logic [4:0] irq_clear4, edge_cap4;
    logic       irq4;
    logic [4:0] irq_clear1, edge_cap1;
    logic       irq1;
`endif

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .NUM_IN      (5),
        .SYNC_STAGES (2),
        .DB_CYCLES   (4),
        .RESET_VAL   (5'b11111)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .din       (din4),
        .dout      (dout4),
        .rise      (rise4),
        .fall      (fall4)
`ifdef INPUT_COND_EDGE_IRQ_EN
       ,.irq_clear (irq_clear4),
        .edge_cap  (edge_cap4),
        .irq       (irq4)
`endif
    );

    input_conditioner #(
        .NUM_IN      (5),
        .SYNC_STAGES (2),
        .DB_CYCLES   (1),
        .RESET_VAL   (5'b11111)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .din       (din1),
        .dout      (dout1),
        .rise      (rise1),
        .fall      (fall1)
`ifdef INPUT_COND_EDGE_IRQ_EN
       ,.irq_clear (irq_clear1),
        .edge_cap  (edge_cap1),
        .irq       (irq1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // din1[2] level sampled at rising edge j of the DB_CYCLES=1 test
    function automatic logic val(input int j);
        if (j < 1) return 1'b1;
        return (((j - 1) / 3) % 2) == 1;
    endfunction

    initial begin
        reset = 1'b1;
        din4  = 5'b11111;
        din1  = 5'b11111;
`ifdef INPUT_COND_EDGE_IRQ_EN
        irq_clear4 = '0;
        irq_clear1 = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_dout", 32'(dout4), 32'(5'b11111));
        check("rst_rise", 32'(rise4), 32'(5'b00000));
        check("rst_fall", 32'(fall4), 32'(5'b00000));
`ifdef INPUT_COND_EDGE_IRQ_EN
        check("rst_cap", 32'(edge_cap4), 32'(5'b00000));
        check("rst_irq", 32'(irq4), 32'(1'b0));
`endif
        reset = 1'b0;

        // Reset release with pins at RESET_VAL: no pulses
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("idle_dout", 32'(dout4), 32'(5'b11111));
            check("idle_edges", 32'(rise4 | fall4), 32'(5'b00000));
        end

        // Channel 0 held low: dout falls after edge 6
        din4[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("ch0_dout", 32'(dout4), (k >= 6) ? 32'(5'b11110) : 32'(5'b11111));
            check("ch0_fall", 32'(fall4), (k == 6) ? 32'(5'b00001) : 32'(5'b00000));
            check("ch0_rise", 32'(rise4), 32'(5'b00000));
        end

        // Channel 3 three-cycle glitch is rejected
        din4[3] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("glitch_dout", 32'(dout4), 32'(5'b11110));
            check("glitch_edges", 32'(rise4 | fall4), 32'(5'b00000));
            if (k == 3) din4[3] = 1'b1;
        end

        // Channel 3 four-cycle pulse passes: fall then rise
        din4[3] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("pulse_dout", 32'(dout4), (k >= 6 && k < 10) ? 32'(5'b10110) : 32'(5'b11110));
            check("pulse_fall", 32'(fall4), (k == 6) ? 32'(5'b01000) : 32'(5'b00000));
            check("pulse_rise", 32'(rise4), (k == 10) ? 32'(5'b01000) : 32'(5'b00000));
            if (k == 4) din4[3] = 1'b1;
        end

`ifdef INPUT_COND_EDGE_IRQ_EN
        // Clear captures from earlier edges
        irq_clear4 = 5'b11111;
        @(negedge clk);
        irq_clear4 = '0;
        check("cap_clr_all", 32'(edge_cap4), 32'(5'b00000));
        check("irq_clr_all", 32'(irq4), 32'(1'b0));

        // fall[4] captured the cycle after the pulse
        din4[4] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin
                check("cap_fall4", 32'(fall4), 32'(5'b10000));
                check("cap_pre", 32'(edge_cap4), 32'(5'b00000));
            end
            if (k == 7) begin
                check("cap_set", 32'(edge_cap4), 32'(5'b10000));
                check("irq_set", 32'(irq4), 32'(1'b1));
            end
        end
        irq_clear4 = 5'b10000;
        @(negedge clk);
        irq_clear4 = '0;
        check("cap_w1c", 32'(edge_cap4), 32'(5'b00000));
        check("irq_w1c", 32'(irq4), 32'(1'b0));

        // rise[4] coincident with clear: set wins
        din4[4] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 6) begin
                check("cap_rise4", 32'(rise4), 32'(5'b10000));
                irq_clear4 = 5'b10000;
            end
        end
        @(negedge clk);
        irq_clear4 = '0;
        check("cap_setwins", 32'(edge_cap4), 32'(5'b10000));
        check("irq_setwins", 32'(irq4), 32'(1'b1));
        irq_clear4 = 5'b10000;
        @(negedge clk);
        irq_clear4 = '0;
        check("cap_clr2", 32'(edge_cap4), 32'(5'b00000));
        check("irq_clr2", 32'(irq4), 32'(1'b0));
`endif

        // Return all pins high and let channel 0 settle
        din4 = 5'b11111;
        repeat (12) @(negedge clk);
        check("settle_dout", 32'(dout4), 32'(5'b11111));

        // Reset in the middle of a channel 1 count
        din4[1] = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_dout", 32'(dout4), 32'(5'b11111));
        check("midrst_edges", 32'(rise4 | fall4), 32'(5'b00000));
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("restart_dout", 32'(dout4), (k >= 6) ? 32'(5'b11101) : 32'(5'b11111));
            check("restart_fall", 32'(fall4), (k == 6) ? 32'(5'b00010) : 32'(5'b00000));
        end

        // DB_CYCLES=1: channel 2 toggles every 3 cycles, 3-edge latency
        din1[2] = val(1);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            check("db1_dout", 32'(dout1), 32'({2'b11, val(k - 2), 2'b11}));
            check("db1_rise", 32'(rise1), 32'({2'b00, val(k - 2) & ~val(k - 3), 2'b00}));
            check("db1_fall", 32'(fall1), 32'({2'b00, ~val(k - 2) & val(k - 3), 2'b00}));
            din1[2] = val(k + 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
